imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Boot-time controller that owns the byte-wide instruction memory. While loading, it holds the CPU
//   in reset and drives the imem address. It accepts a framed byte stream: 2-byte big-endian length,
//   then payload bytes written to consecutive byte addresses starting at 0. When the load completes,
//   it hands the imem address port to the CPU fetch path and releases the CPU.
// PARAMETERS
//   ADDR_BUS_WIDTH  16         imem byte-address width
//   MEM_DEPTH       64         imem size in bytes; upper bound on accepted length
//   TIMEOUT_CYCLES  1000000    max idle cycles between bytes inside a frame before error
// PORTS
//   clk         in   1               system clock
//   rst         in   1               synchronous, active-high reset
//   start       in   1               single-cycle pulse (pre-synchronised); begins a load
//   rx_valid    in   1               byte stream valid
//   rx_data     in   8               byte stream data
//   rx_ready    out  1               loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//   cpu_addr    in   ADDR_BUS_WIDTH  CPU instruction-fetch address
//   imem_addr   out  ADDR_BUS_WIDTH  imem address: mem_waddr when hold, else cpu_addr (combinational)
//   mem_we      out  1               one-cycle imem byte write strobe
//   mem_waddr   out  ADDR_BUS_WIDTH  imem write byte address
//   mem_wdata   out  8               imem write byte
//   cpu_hold    out  1               1 = CPU held in reset
//   load_done   out  1               1 in RUN
//   load_error  out  1               1 in ERR
//   status      out  8               LED view: {state[2:0], byte_cnt[4:0]}
// BEHAVIOUR
//   States: IDLE, LEN_HI, LEN_LO, DATA, CHK (macro only), RUN, ERR. Reset -> IDLE.
//   Reset values: rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, error=0.
//   IDLE: cpu_hold=1. start -> LEN_HI; clear byte_cnt and sum.
//   LEN_HI/LEN_LO: rx_ready=1. Each transfer latches a length byte.
//     After LEN_LO: len==0 -> RUN (or CHK if the macro is defined); len>MEM_DEPTH -> ERR; else -> DATA.
//   DATA: rx_ready=1. Each transfer registers mem_we=1, mem_waddr=byte_cnt, mem_wdata=rx_data on the
//     next cycle (latency 1), then byte_cnt+1. After byte len-1 -> RUN (or CHK). Back-to-back transfers
//     write every cycle.
//   RUN: rx_ready=0, cpu_hold=0, load_done=1. start -> LEN_HI with cpu_hold=1 on the next cycle.
//   ERR: rx_ready=0, cpu_hold=1, load_error=1. start -> LEN_HI. Only start or rst leaves ERR.
//   Timeout: in LEN_HI/LEN_LO/DATA/CHK, the idle counter resets on each transfer. Reaching
//     TIMEOUT_CYCLES -> ERR.
//   start while in LEN_*/DATA/CHK: ignored.
//   rst mid-load: -> IDLE next edge. mem_we is 0 from that edge on. imem contents are not cleared.
//   mem_waddr never exceeds MEM_DEPTH-1. byte_cnt is ADDR_BUS_WIDTH wide, no wrap.
//   status: state code IDLE=0, LEN_HI=1, LEN_LO=2, DATA=3, CHK=4, RUN=5, ERR=6.
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN defined:
//     - An 8-bit running sum (mod 256) covers the payload bytes.
//     - After the last payload byte -> CHK. One more byte is accepted in CHK.
//     - (sum + chk_byte) mod 256 == 0 -> RUN; otherwise -> ERR.
//     - The checksum byte is never written to imem.
//   Not defined: no CHK state and no sum register. The last payload byte -> RUN.
// STRUCTURE
//   imem_loader_defs.vh: state encodings, status codes, LEN_BYTES=2.
//   Sub-module loader_timeout: idle counter with clear/enable inputs and an expired output.
//   Top: FSM, address/data registers, imem_addr mux.
// TESTING
//   1. rst, start, stream 00 04 11 22 33 44 -> writes 11@0, 22@1, 33@2, 44@3; RUN; cpu_hold=0;
//      imem_addr follows cpu_addr.
//   2. Length 00 41 (65 > 64) -> ERR after LEN_LO. No mem_we. start recovers to LEN_HI.
//   3. Stall 2 bytes into a 4-byte frame (TIMEOUT_CYCLES=100) -> ERR at idle cycle 100.
//      cpu_hold stays 1.
//   4. rst asserted after 2 of 4 data bytes -> IDLE next cycle. No further mem_we. cpu_hold=1.
//   5. CHECKSUM_EN: 00 02 10 20 D0 -> RUN. Same frame ending D1 -> ERR. Checksum never written.
//   6. start pulse in DATA and rx_valid in RUN -> both ignored. rx_ready=0 in RUN.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// ============================================================================
// Module      : imem_boot_loader_pkg
// Description : Shared state encodings and helpers for the imem boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_boot_loader_pkg;

  // Encodings double as the status LED state codes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int LEN_BYTES = 2;

  function automatic logic [7:0] status_pack(input state_t s, input logic [4:0] cnt);
    return {s, cnt};
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_boot_loader_timeout.sv
// ============================================================================
// Module      : imem_boot_loader_timeout
// Description : Inter-byte idle counter; flags expiry on the TIMEOUT_CYCLES-th
//               consecutive idle cycle while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != C_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a length-framed byte stream into imem while holding the
//               CPU in reset, then hands the imem address port to the CPU.
//               Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int MEM_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_addr,
  output logic [ADDR_BUS_WIDTH-1:0] imem_addr,
  output logic                      mem_we,
  output logic [ADDR_BUS_WIDTH-1:0] mem_waddr,
  output logic [7:0]                mem_wdata,
  output logic                      cpu_hold,
  output logic                      load_done,
  output logic                      load_error,
  output logic [7:0]                status
);

  localparam int AW = ADDR_BUS_WIDTH;
  localparam logic [15:0] C_MAX_LEN = 16'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [AW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]     mem_waddr_q, mem_waddr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              w_active, w_xfer, w_expired;
  logic [15:0]       w_len_full;
  state_t            w_end_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] w_chk_sum;
  assign w_chk_sum   = sum_q + rx_data;
  assign w_end_state = ST_CHK;
`else
  assign w_end_state = ST_RUN;
`endif

  assign w_active   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign rx_ready   = w_active;
  assign w_xfer     = rx_valid && w_active;
  assign w_len_full = {len_q[15:8], rx_data};

  imem_boot_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_xfer),
    .en_i     (w_active),
    .expired_o(w_expired)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        if (w_xfer) begin
          len_d[15:8] = rx_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          len_d = w_len_full;
          if (w_len_full == 16'd0) begin
            state_d = w_end_state;
          end else if (w_len_full > C_MAX_LEN) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = byte_cnt_q;
          mem_wdata_d = rx_data;
          byte_cnt_d  = byte_cnt_q + AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = w_chk_sum;
`endif
          if ((byte_cnt_q + AW'(1)) == AW'(len_q)) begin
            state_d = w_end_state;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_xfer) begin
          state_d = (w_chk_sum == 8'd0) ? ST_RUN : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Expiry only fires on a cycle without a transfer, so it cannot mask one.
    if (w_expired) begin
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = (state_q != ST_RUN);
  assign load_done  = (state_q == ST_RUN);
  assign load_error = (state_q == ST_ERR);
  assign status     = status_pack(state_q, byte_cnt_q[4:0]);
  assign imem_addr  = cpu_hold ? mem_waddr_q : cpu_addr;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Scoreboard bench for imem_boot_loader (both checksum builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic [AW-1:0] cpu_addr = 16'h1234;
  logic [AW-1:0] imem_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold, load_done, load_error;
  logic [7:0]    status;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  imem_boot_loader #(
    .ADDR_BUS_WIDTH(16),
    .MEM_DEPTH     (64),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cpu_addr  (cpu_addr),
    .imem_addr (imem_addr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error),
    .status    (status)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest expected write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (mem_we) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr !== e.addr || mem_wdata !== e.data)
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_waddr, mem_wdata, e.addr, e.data);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data, input logic [15:0] addr);
    bit got;
    got = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rx_ready) begin
        if (is_data) exp_q.push_back({addr, b});
        got = 1;
      end
      tick();
    end
    rx_valid = 1'b0;
    total_cnt++;
    if (!got) $display("FAIL accept: byte %h not accepted within 20 cycles, expected acceptance", b);
    else pass_cnt++;
  endtask

  task automatic finish_frame(input logic [7:0] chk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk, 1'b0, 16'h0);
`else
    if (chk === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({rx_ready, mem_we, cpu_hold, load_done, load_error} !== 5'b00100 ||
        mem_waddr !== 16'h0 || mem_wdata !== 8'h0 || status !== 8'h00) begin
      $display("FAIL reset: got rdy=%b we=%b hold=%b done=%b err=%b waddr=%h wdata=%h st=%h, expected 0 0 1 0 0 0000 00 00",
               rx_ready, mem_we, cpu_hold, load_done, load_error, mem_waddr, mem_wdata, status);
    end else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (status !== 8'h00 || cpu_hold !== 1'b1) $display("FAIL idle_after_reset: got st=%h hold=%b, expected 00 1", status, cpu_hold);
    else pass_cnt++;
  endtask

  task automatic test_basic_load();
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    total_cnt++;
    if (status !== 8'h20 || rx_ready !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL len_hi: got st=%h rdy=%b imem_addr=%h, expected 20 1 0000", status, rx_ready, imem_addr);
    else pass_cnt++;
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h04, 1'b0, 16'h0);
    total_cnt++;
    if (status[7:5] !== 3'd3) $display("FAIL enter_data: got state=%0d, expected 3", status[7:5]);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) send_byte(d[i], 1'b1, 16'(i));
    finish_frame(8'h56);
    total_cnt++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0 || status !== 8'hA4)
      $display("FAIL run: got done=%b hold=%b rdy=%b st=%h, expected 1 0 0 a4", load_done, cpu_hold, rx_ready, status);
    else pass_cnt++;
    cpu_addr = 16'h0BEE;
    #1;
    total_cnt++;
    if (imem_addr !== 16'h0BEE) $display("FAIL imem_mux: got %h, expected 0bee", imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL basic_writes: got %0d pending writes, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (rx_ready !== 1'b0 || load_done !== 1'b1)
        $display("FAIL run_ignore_rx: got rdy=%b done=%b, expected 0 1", rx_ready, load_done);
      else pass_cnt++;
    end
    rx_valid = 1'b0;
    pulse_start();
    total_cnt++;
    if (cpu_hold !== 1'b1 || status[7:5] !== 3'd1)
      $display("FAIL restart: got hold=%b state=%0d, expected 1 1", cpu_hold, status[7:5]);
    else pass_cnt++;
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h03, 1'b0, 16'h0);
    send_byte(8'hAA, 1'b1, 16'h0);
    pulse_start();
    total_cnt++;
    if (status !== 8'h61) $display("FAIL start_in_data: got st=%h, expected 61", status);
    else pass_cnt++;
    send_byte(8'hBB, 1'b1, 16'h1);
    send_byte(8'hCC, 1'b1, 16'h2);
    finish_frame(8'hCF);
    tick();
    total_cnt++;
    if (load_done !== 1'b1 || exp_q.size() != 0)
      $display("FAIL ignore_load: got done=%b pending=%0d, expected 1 0", load_done, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_full_depth();
    logic [7:0] sum;
    sum = 8'h00;
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h40, 1'b0, 16'h0);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i), 1'b1, 16'(i));
      sum = sum + 8'(i);
    end
    finish_frame(8'(0) - sum);
    tick();
    total_cnt++;
    if (status !== 8'hA0 || exp_q.size() != 0)
      $display("FAIL full_depth: got st=%h pending=%0d, expected a0 0", status, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_len_too_big();
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h41, 1'b0, 16'h0);
    total_cnt++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || status[7:5] !== 3'd6 || rx_ready !== 1'b0)
      $display("FAIL len_err: got err=%b hold=%b state=%0d rdy=%b, expected 1 1 6 0",
               load_error, cpu_hold, status[7:5], rx_ready);
    else pass_cnt++;
    rx_valid = 1'b1;
    repeat (3) tick();
    rx_valid = 1'b0;
    total_cnt++;
    if (status[7:5] !== 3'd6) $display("FAIL err_sticky: got state=%0d, expected 6", status[7:5]);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if (status[7:5] !== 3'd1 || load_error !== 1'b0)
      $display("FAIL err_recover: got state=%0d err=%b, expected 1 0", status[7:5], load_error);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h04, 1'b0, 16'h0);
    send_byte(8'h01, 1'b1, 16'h0);
    send_byte(8'h02, 1'b1, 16'h1);
    repeat (99) tick();
    total_cnt++;
    if (status[7:5] !== 3'd3) $display("FAIL timeout_early: got state=%0d at idle 99, expected 3", status[7:5]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1)
      $display("FAIL timeout: got err=%b hold=%b at idle 100, expected 1 1", load_error, cpu_hold);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_load();
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h04, 1'b0, 16'h0);
    send_byte(8'h55, 1'b1, 16'h0);
    send_byte(8'h66, 1'b1, 16'h1);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    total_cnt++;
    if (status !== 8'h00 || mem_we !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0)
      $display("FAIL rst_mid: got st=%h we=%b hold=%b rdy=%b, expected 00 0 1 0", status, mem_we, cpu_hold, rx_ready);
    else pass_cnt++;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    rx_valid = 1'b0;
    total_cnt++;
    if (status !== 8'h00 || exp_q.size() != 0)
      $display("FAIL rst_idle: got st=%h pending=%0d, expected 00 0", status, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h00, 1'b0, 16'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    total_cnt++;
    if (status !== 8'h80) $display("FAIL zero_len_chk: got st=%h, expected 80", status);
    else pass_cnt++;
    send_byte(8'h00, 1'b0, 16'h0);
`endif
    total_cnt++;
    if (status !== 8'hA0) $display("FAIL zero_len: got st=%h, expected a0", status);
    else pass_cnt++;
  endtask

  task automatic test_checksum();
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h02, 1'b0, 16'h0);
    send_byte(8'h10, 1'b1, 16'h0);
    send_byte(8'h20, 1'b1, 16'h1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    total_cnt++;
    if (status[7:5] !== 3'd4) $display("FAIL enter_chk: got state=%0d, expected 4", status[7:5]);
    else pass_cnt++;
    send_byte(8'hD0, 1'b0, 16'h0);
    total_cnt++;
    if (load_done !== 1'b1) $display("FAIL chk_good: got done=%b, expected 1", load_done);
    else pass_cnt++;
    pulse_start();
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h02, 1'b0, 16'h0);
    send_byte(8'h10, 1'b1, 16'h0);
    send_byte(8'h20, 1'b1, 16'h1);
    send_byte(8'hD1, 1'b0, 16'h0);
    total_cnt++;
    if (load_error !== 1'b1) $display("FAIL chk_bad: got err=%b, expected 1", load_error);
    else pass_cnt++;
`else
    total_cnt++;
    if (load_done !== 1'b1 || rx_ready !== 1'b0)
      $display("FAIL no_chk_run: got done=%b rdy=%b, expected 1 0", load_done, rx_ready);
    else pass_cnt++;
`endif
    repeat (2) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL chk_writes: got %0d pending writes, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_ignore();
    test_full_depth();
    test_len_too_big();
    test_timeout();
    test_rst_mid_load();
    test_zero_len();
    test_checksum();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
